// File: rtl/rsa_seq_pkg.sv
// Shared types and constants for the RSA job sequencer: state enum,
// default operand width and display window selectors.
package rsa_seq_pkg;

    localparam int RSA_BITS = 64;
    localparam int WIN_W    = 16;

    localparam logic [1:0] WIN_SEL_0 = 2'd0;  // result[15:0]
    localparam logic [1:0] WIN_SEL_1 = 2'd1;  // result[31:16]
    localparam logic [1:0] WIN_SEL_2 = 2'd2;  // result[47:32]
    localparam logic [1:0] WIN_SEL_3 = 2'd3;  // result[63:48]

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOADED = 3'd1,
        ST_RUN    = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } seq_state_t;

    // Pick one 16-bit display window out of the low 64 bits of a value.
    function automatic logic [WIN_W-1:0] window16(input logic [63:0] value,
                                                  input logic [1:0]  sel);
        logic [WIN_W-1:0] w;
        case (sel)
            WIN_SEL_0: w = value[15:0];
            WIN_SEL_1: w = value[31:16];
            WIN_SEL_2: w = value[47:32];
            default:   w = value[63:48];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rsa_operand_check.sv
// Combinational operand validation on the capture path: the modulus must be
// odd and greater than one (Montgomery needs an odd modulus), and the message
// must already be reduced (M < N).
module rsa_operand_check
    import rsa_seq_pkg::*;
#(
    parameter int BITS = RSA_BITS
) (
    input  logic [BITS-1:0] msg,
    input  logic [BITS-1:0] modulus,
    output logic            ok
);

    assign ok = modulus[0] && (modulus > BITS'(1)) && (msg < modulus);

endmodule

// File: rtl/rsa_job_sequencer.sv
// Control/operand stage in front of the Montgomery exponentiation engine.
// Captures and validates operands on load, runs the engine with a timeout,
// latches the result and presents a registered 16-bit display window.
// Optional feature: define RSA_CYCLE_COUNT_EN to build the run-length counter
// behind cycle_count; otherwise cycle_count is tied to zero.
module rsa_job_sequencer
    import rsa_seq_pkg::*;
#(
    parameter int BITS        = RSA_BITS,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic            sysclk,
    input  logic            sysreset,
    input  logic            load,
    input  logic            start,
    input  logic            stop,
    input  logic [BITS-1:0] msg_in,
    input  logic [BITS-1:0] exp_in,
    input  logic [BITS-1:0] mod_in,
    output logic [BITS-1:0] m_out,
    output logic [BITS-1:0] e_out,
    output logic [BITS-1:0] n_out,
    output logic            go,
    input  logic            eng_done,
    input  logic [BITS-1:0] eng_result,
    output logic [BITS-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            error,
    input  logic [1:0]      win_sel,
    output logic [15:0]     display,
    output logic [31:0]     cycle_count
);

    // Timer holds 0 .. TIMEOUT_CYC-1, the index of the current RUN cycle.
    localparam int            TW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    seq_state_t      state_q, state_d;
    logic [BITS-1:0] m_q, m_d;
    logic [BITS-1:0] e_q, e_d;
    logic [BITS-1:0] n_q, n_d;
    logic [BITS-1:0] result_q, result_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     display_q, display_d;
    logic            ops_ok;

    rsa_operand_check #(.BITS(BITS)) u_operand_check (
        .msg     (msg_in),
        .modulus (mod_in),
        .ok      (ops_ok)
    );

    // Next-state, operand capture, result latch and run timer.
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        e_d      = e_q;
        n_d      = n_q;
        result_d = result_q;
        timer_d  = timer_q;
        case (state_q)
            ST_RUN: begin
                timer_d = timer_q + 1'b1;
                // stop > eng_done > timeout; eng_done on the first RUN cycle
                // (timer still 0) is stale from a previous job and is ignored.
                if (stop) begin
                    state_d = ST_LOADED;
                end else if (eng_done && (timer_q != '0)) begin
                    result_d = eng_result;
                    state_d  = ST_DONE;
                end else if (timer_q == TMAX) begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                // load beats start when both arrive together.
                if (load) begin
                    m_d      = msg_in;
                    e_d      = exp_in;
                    n_d      = mod_in;
                    result_d = '0;
                    state_d  = ops_ok ? ST_LOADED : ST_ERR;
                end else if (start && ((state_q == ST_LOADED) || (state_q == ST_DONE))) begin
                    timer_d = '0;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // Display window follows the latched result one cycle later.
    always_comb begin
        display_d = window16(64'(result_q), win_sel);
    end

    // State, operand, result, timer and display registers.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            e_q       <= '0;
            n_q       <= '0;
            result_q  <= '0;
            timer_q   <= '0;
            display_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            e_q       <= e_d;
            n_q       <= n_d;
            result_q  <= result_d;
            timer_q   <= timer_d;
            display_q <= display_d;
        end
    end

`ifdef RSA_CYCLE_COUNT_EN
    logic [31:0] count_q, count_d;

    // Run-length counter: cleared on RUN entry, +1 per RUN cycle, saturating.
    always_comb begin
        count_d = count_q;
        if (state_q == ST_RUN) begin
            if (count_q != 32'hFFFF_FFFF) begin
                count_d = count_q + 32'd1;
            end
        end else if (state_d == ST_RUN) begin
            count_d = '0;
        end
    end

    // Run-length counter register.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign cycle_count = count_q;
`else
    assign cycle_count = '0;
`endif

    assign m_out   = m_q;
    assign e_out   = e_q;
    assign n_out   = n_q;
    assign result  = result_q;
    assign display = display_q;
    assign go      = (state_q == ST_RUN);
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign error   = (state_q == ST_ERR);

endmodule
